// File: rtl/gi_popcount_arbiter_if.sv
// Request/result bus of the shared ones-counter: two sample requesters in, one tagged result out.
// The master modport is the sensor/consumer side; the slave modport is the counter.
interface gi_popcount_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              res_valid;
    logic              res_ready;
    logic              res_ch;
    logic [CNT_W-1:0]  res_count;
    logic              busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_ch, res_count, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_ch, res_count, busy
    );
endinterface

// File: rtl/gi_popcount_arbiter.sv
// Round-robin shared bit-serial ones-counter for two sample channels (glycemic index result).
// Optional GI_EARLY_EXIT_EN: leave COUNT as soon as no 1 bits remain in the shift register.
module gi_popcount_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gi_popcount_arbiter_if.slave   bus
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        RESULT
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shiftReg_q;
    logic [DATA_W-1:0] shiftReg_d;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  acc_d;
    logic [IDX_W-1:0]  bitIdx_q;
    logic              ch_q;
    logic              lastGrant_q;
    logic              resValid_q;
    logic              resCh_q;
    logic [CNT_W-1:0]  resCount_q;
    logic              busy_q;
    logic              grant0;
    logic              grant1;
    logic              countDone;

    // A tie goes to the channel that was not granted last; ready is held low while in reset.
    always_comb begin
        grant0 = rst_n && (state_q == IDLE) && bus.req0_valid
                 && (!bus.req1_valid || lastGrant_q);
        grant1 = rst_n && (state_q == IDLE) && bus.req1_valid
                 && (!bus.req0_valid || !lastGrant_q);
    end

    always_comb begin
        shiftReg_d = shiftReg_q >> 1;
        acc_d      = acc_q + CNT_W'(shiftReg_q[0]);
`ifdef GI_EARLY_EXIT_EN
        countDone  = (bitIdx_q == IDX_W'(DATA_W - 1)) || (shiftReg_d == '0);
`else
        countDone  = (bitIdx_q == IDX_W'(DATA_W - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            acc_q       <= '0;
            bitIdx_q    <= '0;
            ch_q        <= 1'b0;
            lastGrant_q <= 1'b1;
            resValid_q  <= 1'b0;
            resCh_q     <= 1'b0;
            resCount_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        shiftReg_q  <= grant1 ? bus.req1_data : bus.req0_data;
                        ch_q        <= grant1;
                        lastGrant_q <= grant1;
                        acc_q       <= '0;
                        bitIdx_q    <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= COUNT;
                    end
                end
                COUNT: begin
                    shiftReg_q <= shiftReg_d;
                    acc_q      <= acc_d;
                    bitIdx_q   <= bitIdx_q + IDX_W'(1);
                    if (countDone) begin
                        resValid_q <= 1'b1;
                        resCount_q <= acc_d;
                        resCh_q    <= ch_q;
                        state_q    <= RESULT;
                    end
                end
                RESULT: begin
                    // The result is held until the consumer takes it; no new grant in this cycle.
                    if (bus.res_ready) begin
                        resValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = resValid_q;
    assign bus.res_ch     = resCh_q;
    assign bus.res_count  = resCount_q;
    assign bus.busy       = busy_q;

endmodule
